// File: rtl/alu_arb.sv
// alu_arb: two-requester round-robin arbiter in front of a shared combinational ALU, with a one-deep result slot per requester.
// Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters (GNT_CNT0/GNT_CNT1).
module alu_arb #(
   parameter int INIT_PRI = 0
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic [1:0]  REQ_VALID,
   output logic [1:0]  REQ_READY,
   input  logic [7:0]  REQ_OP,
   input  logic [63:0] REQ_A,
   input  logic [63:0] REQ_B,
   output logic [1:0]  RSP_VALID,
   output logic [63:0] RSP_DATA,
   input  logic [1:0]  RSP_READY,
   output logic [3:0]  ALUOP_E,
   output logic [31:0] ALUSRC1,
   output logic [31:0] ALUSRC2,
   input  logic [31:0] ALUOUT_E
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0] GNT_CNT0,
   output logic [15:0] GNT_CNT1
`endif
);
   logic       ptr;
   logic       sel;
   logic [1:0] elig;
   logic [1:0] gnt;
   // A slot that drains this cycle can accept a new result at the same edge.
   always_comb begin
      elig = RSTN ? REQ_VALID & (~RSP_VALID | RSP_READY) : 2'b00;
      sel = (&elig) ? ptr : elig[1];
      gnt = (|elig) ? (sel ? 2'b10 : 2'b01) : 2'b00;
      REQ_READY = gnt;
      ALUOP_E = gnt[1] ? REQ_OP[7:4] : gnt[0] ? REQ_OP[3:0] : 4'd0;
      ALUSRC1 = gnt[1] ? REQ_A[63:32] : gnt[0] ? REQ_A[31:0] : 32'd0;
      ALUSRC2 = gnt[1] ? REQ_B[63:32] : gnt[0] ? REQ_B[31:0] : 32'd0;
   end
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         RSP_VALID <= 2'b00;
         RSP_DATA <= 64'd0;
         ptr <= 1'(INIT_PRI);
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (gnt[n]) begin
               RSP_VALID[n] <= 1'b1;
               RSP_DATA[n*32 +: 32] <= ALUOUT_E;
            end else if (RSP_READY[n]) begin
               RSP_VALID[n] <= 1'b0;
            end
         end
         if (|gnt) ptr <= ~sel;
      end
   end
`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         GNT_CNT0 <= 16'd0;
         GNT_CNT1 <= 16'd0;
      end else begin
         if (gnt[0] && !(&GNT_CNT0)) GNT_CNT0 <= GNT_CNT0 + 16'd1;
         if (gnt[1] && !(&GNT_CNT1)) GNT_CNT1 <= GNT_CNT1 + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed and randomized checks of alu_arb against a cycle-level reference model; the bench also plays the shared ALU.
module tb_alu_arb;
   localparam int INIT_PRI = 0;
   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [7:0]  req_op;
   logic [63:0] req_a, req_b, rsp_data;
   logic [3:0]  aluop_e;
   logic [31:0] alusrc1, alusrc2, aluout_e;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif
   int          checks = 0;
   int          failures = 0;
   bit          m_v [2];
   logic [31:0] m_d [2];
   int          m_ptr;
   int          m_cnt [2];

   alu_arb #(.INIT_PRI(INIT_PRI)) dut (
      .CLK(clk), .RSTN(rstn),
      .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_OP(req_op), .REQ_A(req_a), .REQ_B(req_b),
      .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_READY(rsp_ready),
      .ALUOP_E(aluop_e), .ALUSRC1(alusrc1), .ALUSRC2(alusrc2), .ALUOUT_E(aluout_e)
`ifdef ALU_ARB_STATS_EN
      , .GNT_CNT0(gnt_cnt0), .GNT_CNT1(gnt_cnt1)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: return a & b;
         4'd1: return a + b;
         4'd2: return a - b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd11: return 32'($signed(a) >>> b[4:0]);
         default: return ~(a ^ b) + {28'd0, op};
      endcase
   endfunction

   assign aluout_e = alu_f(aluop_e, alusrc1, alusrc2);

   // Index the arbiter should grant now, or -1 for none.
   function automatic int model_grant();
      bit e0, e1;
      if (!rstn) return -1;
      e0 = req_valid[0] && (!m_v[0] || rsp_ready[0]);
      e1 = req_valid[1] && (!m_v[1] || rsp_ready[1]);
      if (e0 && e1) return m_ptr;
      if (e0) return 0;
      if (e1) return 1;
      return -1;
   endfunction

   task automatic tick();
      int g;
      g = model_grant();
      @(posedge clk);
      if (!rstn) begin
         m_v = '{0, 0};
         m_d = '{32'd0, 32'd0};
         m_ptr = INIT_PRI;
         m_cnt = '{0, 0};
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (g == n) begin
               m_v[n] = 1'b1;
               m_d[n] = alu_f(req_op[n*4 +: 4], req_a[n*32 +: 32], req_b[n*32 +: 32]);
               if (m_cnt[n] < 65535) m_cnt[n]++;
            end else if (rsp_ready[n]) begin
               m_v[n] = 1'b0;
            end
         end
         if (g >= 0) m_ptr = 1 - g;
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] r, input logic [3:0] op0, input logic [3:0] op1,
                        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] b0, input logic [31:0] b1);
      req_valid = v;
      rsp_ready = r;
      req_op = {op1, op0};
      req_a = {a1, a0};
      req_b = {b1, b0};
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      drive(2'b11, 2'b11, 4'd1, 4'd1, 7, 7, 7, 7);
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      checks++; if ({aluop_e, alusrc1, alusrc2} !== 68'd0) begin failures++; $display("FAIL reset_alu: got op=%h s1=%h s2=%h want 0", aluop_e, alusrc1, alusrc2); end
      tick();
      tick();
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      checks++; if (rsp_data !== 64'd0) begin failures++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
`ifdef ALU_ARB_STATS_EN
      checks++; if ({gnt_cnt1, gnt_cnt0} !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %h/%h want 0", gnt_cnt1, gnt_cnt0); end
`endif
      rstn = 1'b1;
   endtask

   task automatic test_single_add();
      drive(2'b01, 2'b00, 4'd1, 4'd0, 5, 0, 3, 0);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL add_ready: got %b want 01", req_ready); end
      checks++; if (aluop_e !== 4'd1 || alusrc1 !== 32'd5 || alusrc2 !== 32'd3) begin failures++; $display("FAIL add_alu: got op=%h s1=%h s2=%h want 1/5/3", aluop_e, alusrc1, alusrc2); end
      tick();
      drive(2'b00, 2'b00, 4'd0, 4'd0, 0, 0, 0, 0);
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL add_rsp_valid: got %b want 01", rsp_valid); end
      checks++; if (rsp_data[31:0] !== 32'd8) begin failures++; $display("FAIL add_rsp_data: got %h want 8", rsp_data[31:0]); end
      checks++; if ({aluop_e, alusrc1, alusrc2} !== 68'd0) begin failures++; $display("FAIL idle_alu: got op=%h s1=%h s2=%h want 0", aluop_e, alusrc1, alusrc2); end
      drive(2'b00, 2'b01, 4'd0, 4'd0, 0, 0, 0, 0);
      tick();
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL add_drain: got %b want 00", rsp_valid); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_seq [4];
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
      rstn = 1'b0;
      drive(2'b00, 2'b00, 4'd0, 4'd0, 0, 0, 0, 0);
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2'b11, 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom);
         checks++; if (req_ready !== exp_seq[i]) begin failures++; $display("FAIL contention_%0d: got %b want %b", i, req_ready, exp_seq[i]); end
         tick();
      end
      drive(2'b00, 2'b11, 4'd0, 4'd0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_backpressure();
      drive(2'b01, 2'b00, 4'd4, 4'd0, 32'h1234, 0, 32'hFF00, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(2'b01, 2'b00, 4'd1, 4'd0, $urandom, 0, $urandom, 0);
         checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_ready_%0d: got %b want 0", i, req_ready[0]); end
         checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== 32'hED34) begin failures++; $display("FAIL bp_hold_%0d: got v=%b d=%h want 1/0000ed34", i, rsp_valid[0], rsp_data[31:0]); end
         tick();
      end
      drive(2'b00, 2'b01, 4'd0, 4'd0, 0, 0, 0, 0);
      tick();
      checks++; if (rsp_valid[0] !== 1'b0 || rsp_data[31:0] !== 32'hED34) begin failures++; $display("FAIL bp_release: got v=%b d=%h want 0/0000ed34", rsp_valid[0], rsp_data[31:0]); end
   endtask

   task automatic test_drain_refill();
      drive(2'b01, 2'b00, 4'd1, 4'd0, 10, 0, 20, 0);
      tick();
      drive(2'b01, 2'b01, 4'd11, 4'd0, 32'h80000001, 0, 1, 0);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL refill_ready: got %b want 01", req_ready); end
      tick();
      drive(2'b00, 2'b00, 4'd0, 4'd0, 0, 0, 0, 0);
      checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== 32'hC0000000) begin failures++; $display("FAIL refill_data: got v=%b d=%h want 1/c0000000", rsp_valid[0], rsp_data[31:0]); end
      drive(2'b00, 2'b11, 4'd0, 4'd0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset_mid();
      drive(2'b01, 2'b11, 4'd1, 4'd0, 1, 0, 1, 0);
      tick();
      drive(2'b01, 2'b11, 4'd1, 4'd0, 2, 0, 2, 0);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_pre_ready: got %b want 01", req_ready); end
      rstn = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b00 || aluop_e !== 4'd0 || alusrc1 !== 32'd0) begin failures++; $display("FAIL mid_forced: got rdy=%b op=%h s1=%h want 0", req_ready, aluop_e, alusrc1); end
      tick();
      rstn = 1'b1;
      drive(2'b00, 2'b00, 4'd0, 4'd0, 0, 0, 0, 0);
      checks++; if (rsp_valid !== 2'b00 || rsp_data !== 64'd0) begin failures++; $display("FAIL mid_discard: got v=%b d=%h want 0", rsp_valid, rsp_data); end
      drive(2'b11, 2'b11, 4'd2, 4'd3, 9, 9, 4, 4);
      checks++; if (req_ready !== (INIT_PRI != 0 ? 2'b10 : 2'b01)) begin failures++; $display("FAIL mid_ptr: got %b want init priority %0d", req_ready, INIT_PRI); end
      tick();
      drive(2'b00, 2'b11, 4'd0, 4'd0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_random();
      int g;
      logic [1:0] er;
      for (int i = 0; i < 400; i++) begin
         rstn = ($urandom_range(0, 39) != 0);
         drive(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom);
         g = model_grant();
         er = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
         checks++; if (req_ready !== er) begin failures++; $display("FAIL rnd_ready_%0d: got %b want %b", i, req_ready, er); end
         checks++; if (aluop_e !== (g < 0 ? 4'd0 : req_op[g*4 +: 4])) begin failures++; $display("FAIL rnd_op_%0d: got %h", i, aluop_e); end
         checks++; if (alusrc1 !== (g < 0 ? 32'd0 : req_a[g*32 +: 32]) || alusrc2 !== (g < 0 ? 32'd0 : req_b[g*32 +: 32])) begin failures++; $display("FAIL rnd_src_%0d: got %h/%h", i, alusrc1, alusrc2); end
         checks++; if (rsp_valid !== {m_v[1], m_v[0]}) begin failures++; $display("FAIL rnd_rsp_valid_%0d: got %b want %b", i, rsp_valid, {m_v[1], m_v[0]}); end
         checks++; if (rsp_data !== {m_d[1], m_d[0]}) begin failures++; $display("FAIL rnd_rsp_data_%0d: got %h want %h", i, rsp_data, {m_d[1], m_d[0]}); end
`ifdef ALU_ARB_STATS_EN
         checks++; if (gnt_cnt0 !== 16'(m_cnt[0]) || gnt_cnt1 !== 16'(m_cnt[1])) begin failures++; $display("FAIL rnd_cnt_%0d: got %0d/%0d want %0d/%0d", i, gnt_cnt0, gnt_cnt1, m_cnt[0], m_cnt[1]); end
`endif
         tick();
      end
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_single_add();
      test_contention();
      test_backpressure();
      test_drain_refill();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
